dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data SRAM (1024x32, 1-cycle read latency, byte-masked write) between two requesters: the core load/store port (CORE) and the DMA/program-loader port (DMA).
- Fixed priority to CORE, with an anti-starvation counter that forces a DMA grant after a bounded wait.
- Returns read data, with a valid strobe, to the requester that issued the read.
- Sits between the core/DMA interconnect and dmem.

Parameters:
- MEM_ADDR_WIDTH, 12, byte-address bits forwarded to SRAM (word index = addr[MEM_ADDR_WIDTH-1:2]).
- MAX_WAIT, 4, consecutive cycles DMA may be refused before a forced grant (1..15).
- WAIT_W, 4, width of the starvation counter.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_core_req  in  1  CORE access request
- i_core_we  in  1  1=write, 0=read
- i_core_addr  in  32  byte address
- i_core_wdata  in  32  write data
- i_core_size  in  4  byte-lane mask
- o_core_gnt  out  1  request accepted this cycle
- o_core_rvalid  out  1  read data valid
- o_core_rdata  out  32  read data
- i_dma_req, i_dma_we, i_dma_addr[32], i_dma_wdata[32], i_dma_size[4]  in  DMA request fields, same meaning as CORE
- o_dma_gnt, o_dma_rvalid, o_dma_rdata[32]  out  DMA grant/response, same meaning as CORE
- o_mem_addr  out  32  to SRAM address
- o_mem_wr_data  out  32  to SRAM write data
- o_mem_size  out  4  to SRAM byte mask
- o_mem_write  out  1  SRAM write enable
- o_mem_read  out  1  SRAM read enable
- i_mem_rd_data  in  32  SRAM Q, valid the cycle after o_mem_read

Behaviour:
- Clock and reset: one clock domain, i_clk. Reset is i_rst, asynchronous and active-high.
- Reset values: all registered state cleared. o_*_rvalid=0, o_*_rdata=0, wait counter=0, state=PRI_CORE. While i_rst is high, o_*_gnt=0, o_mem_write=0 and o_mem_read=0.
- Grant timing: grant is combinational in the request cycle. Exactly one gnt is high per cycle, at most.
- FSM state PRI_CORE:
  - If i_core_req, CORE is granted.
  - Else if i_dma_req, DMA is granted.
  - When DMA is refused while requesting, wait_cnt increments.
  - When wait_cnt reaches MAX_WAIT-1 and DMA is refused again, the next state is FORCE_DMA.
- FSM state FORCE_DMA:
  - DMA is granted if requesting; CORE is stalled (gnt=0).
  - Next state is PRI_CORE. wait_cnt clears.
  - If DMA dropped its request, the state returns to PRI_CORE with no grant issued.
- wait_cnt clears on any DMA grant or when i_dma_req is low. It never wraps; it saturates at MAX_WAIT-1.
- Memory mux:
  - The granted requester's addr/wdata/size drive o_mem_*.
  - o_mem_write = gnt & we.
  - o_mem_read = gnt & ~we.
  - With no grant, o_mem_* hold 0.
- Read return:
  - A 1-bit owner register captures the granted requester on a read.
  - Next cycle, the owner's rvalid=1 and rdata is registered through from i_mem_rd_data. Read latency is 1 cycle from grant.
  - The non-owner's rvalid stays 0 and its rdata holds its last value.
  - Back-to-back reads from alternating requesters each return correctly.
- Writes produce no rvalid.
- Write then read to the same address on consecutive cycles returns the new data; this relies on SRAM behaviour and is not forwarded here.
- Simultaneous request in PRI_CORE: CORE wins.
- Reset mid-read: the pending rvalid is dropped and never asserted.
- Address bits above MEM_ADDR_WIDTH are passed through unchanged; decoding is done upstream.

Optional Feature:
- DMEM_ARB_PERF_EN defined:
  - Adds three 32-bit wrapping counters: core_grants, dma_grants, dma_forced.
  - Adds two outputs: o_perf_core_gnt_cnt[32] and o_perf_dma_stall_cnt[32], counting cycles DMA is requesting but not granted.
  - All counters clear on reset.
- DMEM_ARB_PERF_EN undefined: no counters and no perf ports exist.

Decomposition:
- Package dmem_pkg holds:
  - typedef enum logic {PRI_CORE, FORCE_DMA} arb_state_e
  - typedef enum logic {OWN_CORE, OWN_DMA} owner_e
  - typedef struct req_t {req, we, addr, wdata, size}
  - localparam DMEM_RD_LAT=1
- One sub-module is natural: dmem_arb_starve_cnt, the saturating wait counter plus forced-grant flag.

Test Plan:
- CORE-only read: write 0xDEADBEEF to 0x010, then read 0x010. Expect o_core_gnt the same cycle, o_core_rvalid one cycle later with 0xDEADBEEF, and o_dma_rvalid=0.
- Simultaneous read requests, MAX_WAIT=4: CORE is granted for 4 cycles. On the 5th cycle o_dma_gnt=1 and o_core_gnt=0, then the state returns to PRI_CORE.
- Alternating grants, CORE read 0x004 then DMA read 0x008: each rvalid goes to the correct port with its own data and never crosses.
- Byte write, DMA writes size=4'b0010 data 0x0000AB00 to a word holding 0x11223344: a later read returns 0x1122AB44.
- Reset mid-read: assert i_rst in the cycle after a CORE read grant. Expect no rvalid, all gnt=0, state=PRI_CORE and wait_cnt=0 after release.
- DMA drops its request in FORCE_DMA: no grant is issued, and CORE is granted in the next cycle.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types for the data-memory arbiter.
//   arb_state_e - arbiter FSM states (normal CORE priority / forced DMA slot)
//   owner_e     - which requester a pending read belongs to
//   req_t       - one requester's access fields
//   DMEM_RD_LAT - SRAM read latency in cycles (grant to Q valid)
package dmem_pkg;

    typedef enum logic {PRI_CORE = 1'b0, FORCE_DMA = 1'b1} arb_state_e;

    typedef enum logic {OWN_CORE = 1'b0, OWN_DMA = 1'b1} owner_e;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  size;
    } req_t;

    localparam int DMEM_RD_LAT = 1;

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// dmem_arb_starve_cnt: saturating count of consecutive DMA refusals.
//   i_clk, i_rst - clock, async active-high reset
//   i_inc        - DMA requested and was refused this cycle
//   i_clr        - DMA granted, idle, or the forced slot is being served
//   o_at_limit   - counter sits at MAX_WAIT-1; one more refusal must force DMA
module dmem_arb_starve_cnt #(
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_limit
);

    logic [WAIT_W-1:0] wait_cnt;

    assign o_at_limit = (wait_cnt == WAIT_W'(MAX_WAIT - 1));

    // Saturates rather than wraps so a long refusal streak never looks short.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            wait_cnt <= '0;
        else if (i_clr)
            wait_cnt <= '0;
        else if (i_inc && !o_at_limit)
            wait_cnt <= wait_cnt + 1'b1;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data SRAM between CORE and DMA.
//   CORE has fixed priority; after MAX_WAIT consecutive DMA refusals the
//   next cycle is reserved for DMA. Grants are combinational; read data
//   returns DMEM_RD_LAT cycles later with rvalid on the issuing port only.
// Ports:
//   i_clk, i_rst                      - clock, async active-high reset
//   i_core_* / o_core_*               - CORE request, grant, read return
//   i_dma_*  / o_dma_*                - DMA request, grant, read return
//   o_mem_*                           - SRAM address/data/mask/enables
//   i_mem_rd_data                     - SRAM Q, valid the cycle after a read
// Build option DMEM_ARB_PERF_EN adds grant/stall counters and the
//   o_perf_core_gnt_cnt / o_perf_dma_stall_cnt ports.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 12,
    parameter int MAX_WAIT       = 4,
    parameter int WAIT_W         = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_core_req,
    input  logic        i_core_we,
    input  logic [31:0] i_core_addr,
    input  logic [31:0] i_core_wdata,
    input  logic [3:0]  i_core_size,
    output logic        o_core_gnt,
    output logic        o_core_rvalid,
    output logic [31:0] o_core_rdata,
    input  logic        i_dma_req,
    input  logic        i_dma_we,
    input  logic [31:0] i_dma_addr,
    input  logic [31:0] i_dma_wdata,
    input  logic [3:0]  i_dma_size,
    output logic        o_dma_gnt,
    output logic        o_dma_rvalid,
    output logic [31:0] o_dma_rdata,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wr_data,
    output logic [3:0]  o_mem_size,
    output logic        o_mem_write,
    output logic        o_mem_read,
    input  logic [31:0] i_mem_rd_data
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0] o_perf_core_gnt_cnt,
    output logic [31:0] o_perf_dma_stall_cnt
`endif
);

    arb_state_e state, state_nxt;
    logic       core_gnt, dma_gnt;
    logic       at_limit;
    req_t       core_r, dma_r, mem_r;

    assign core_r = '{req: i_core_req, we: i_core_we, addr: i_core_addr,
                      wdata: i_core_wdata, size: i_core_size};
    assign dma_r  = '{req: i_dma_req, we: i_dma_we, addr: i_dma_addr,
                      wdata: i_dma_wdata, size: i_dma_size};

    // ---------------- arbitration FSM ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state <= PRI_CORE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        core_gnt  = 1'b0;
        dma_gnt   = 1'b0;
        if (!i_rst) begin
            unique case (state)
                PRI_CORE: begin
                    if (i_core_req)
                        core_gnt = 1'b1;
                    else if (i_dma_req)
                        dma_gnt = 1'b1;
                    // Refused again while already at the limit: reserve next cycle.
                    if (i_core_req && i_dma_req && at_limit)
                        state_nxt = FORCE_DMA;
                end
                FORCE_DMA: begin
                    // CORE is stalled; if DMA has gone away the slot is simply lost.
                    dma_gnt   = i_dma_req;
                    state_nxt = PRI_CORE;
                end
                default: state_nxt = PRI_CORE;
            endcase
        end
    end

    assign o_core_gnt = core_gnt;
    assign o_dma_gnt  = dma_gnt;

    dmem_arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_starve (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_inc      (i_dma_req && !dma_gnt && state == PRI_CORE),
        .i_clr      (!i_dma_req || dma_gnt || state == FORCE_DMA),
        .o_at_limit (at_limit)
    );

    // ---------------- memory mux ----------------
    always_comb begin
        mem_r = '0;
        if (core_gnt)
            mem_r = core_r;
        else if (dma_gnt)
            mem_r = dma_r;
    end

    // SRAM only decodes the low MEM_ADDR_WIDTH bits; the rest ride along untouched.
    assign o_mem_addr    = {mem_r.addr[31:MEM_ADDR_WIDTH], mem_r.addr[MEM_ADDR_WIDTH-1:0]};
    assign o_mem_wr_data = mem_r.wdata;
    assign o_mem_size    = mem_r.size;
    assign o_mem_write   = mem_r.req & mem_r.we;
    assign o_mem_read    = mem_r.req & ~mem_r.we;

    // ---------------- read return ----------------
    // vld_pipe/own_pipe track an issued read until its SRAM data is on Q.
    logic [DMEM_RD_LAT:1] vld_pipe;
    logic [DMEM_RD_LAT:1] own_pipe;
    logic                 rd_done;
    owner_e               rd_owner;
    logic [31:0]          core_rdata_q, dma_rdata_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_pipe <= '0;
            own_pipe <= '0;
        end else begin
            vld_pipe <= (vld_pipe << 1) | DMEM_RD_LAT'(o_mem_read);
            own_pipe <= (own_pipe << 1) | DMEM_RD_LAT'(dma_gnt);
        end
    end

    assign rd_done       = vld_pipe[DMEM_RD_LAT];
    assign rd_owner      = owner_e'(own_pipe[DMEM_RD_LAT]);
    assign o_core_rvalid = rd_done && rd_owner == OWN_CORE;
    assign o_dma_rvalid  = rd_done && rd_owner == OWN_DMA;

    // Q is only valid in the return cycle; each port keeps its last word after.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            core_rdata_q <= '0;
            dma_rdata_q  <= '0;
        end else begin
            if (o_core_rvalid) core_rdata_q <= i_mem_rd_data;
            if (o_dma_rvalid)  dma_rdata_q  <= i_mem_rd_data;
        end
    end

    assign o_core_rdata = o_core_rvalid ? i_mem_rd_data : core_rdata_q;
    assign o_dma_rdata  = o_dma_rvalid  ? i_mem_rd_data : dma_rdata_q;

`ifdef DMEM_ARB_PERF_EN
    // ---------------- performance counters (wrap at 2^32) ----------------
    logic [31:0] core_grants, dma_grants, dma_forced, dma_stalls;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            core_grants <= '0;
            dma_grants  <= '0;
            dma_forced  <= '0;
            dma_stalls  <= '0;
        end else begin
            core_grants <= core_grants + 32'(core_gnt);
            dma_grants  <= dma_grants  + 32'(dma_gnt);
            dma_forced  <= dma_forced  + 32'(dma_gnt && state == FORCE_DMA);
            dma_stalls  <= dma_stalls  + 32'(i_dma_req && !dma_gnt);
        end
    end

    assign o_perf_core_gnt_cnt  = core_grants;
    assign o_perf_dma_stall_cnt = dma_stalls;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus a randomized run against a
// transaction-level model (refusal streak count, golden word array,
// expected read-return queue). Includes a 1-cycle-latency byte-masked SRAM.
module tb_dmem_arbiter;

    localparam int MAX_WAIT = 4;

    logic        i_clk, i_rst;
    logic        i_core_req, i_core_we;
    logic [31:0] i_core_addr, i_core_wdata;
    logic [3:0]  i_core_size;
    logic        o_core_gnt, o_core_rvalid;
    logic [31:0] o_core_rdata;
    logic        i_dma_req, i_dma_we;
    logic [31:0] i_dma_addr, i_dma_wdata;
    logic [3:0]  i_dma_size;
    logic        o_dma_gnt, o_dma_rvalid;
    logic [31:0] o_dma_rdata;
    logic [31:0] o_mem_addr, o_mem_wr_data;
    logic [3:0]  o_mem_size;
    logic        o_mem_write, o_mem_read;
    logic [31:0] i_mem_rd_data;

    int checks   = 0;
    int failures = 0;

    dmem_arbiter #(.MEM_ADDR_WIDTH(12), .MAX_WAIT(MAX_WAIT), .WAIT_W(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_core_req(i_core_req), .i_core_we(i_core_we), .i_core_addr(i_core_addr),
        .i_core_wdata(i_core_wdata), .i_core_size(i_core_size),
        .o_core_gnt(o_core_gnt), .o_core_rvalid(o_core_rvalid), .o_core_rdata(o_core_rdata),
        .i_dma_req(i_dma_req), .i_dma_we(i_dma_we), .i_dma_addr(i_dma_addr),
        .i_dma_wdata(i_dma_wdata), .i_dma_size(i_dma_size),
        .o_dma_gnt(o_dma_gnt), .o_dma_rvalid(o_dma_rvalid), .o_dma_rdata(o_dma_rdata),
        .o_mem_addr(o_mem_addr), .o_mem_wr_data(o_mem_wr_data), .o_mem_size(o_mem_size),
        .o_mem_write(o_mem_write), .o_mem_read(o_mem_read), .i_mem_rd_data(i_mem_rd_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // SRAM: byte-masked write, Q registered one cycle after a read.
    logic [31:0] sram [0:1023];
    logic [31:0] sram_q = 32'h0;
    always @(posedge i_clk) begin
        if (o_mem_write)
            for (int b = 0; b < 4; b++)
                if (o_mem_size[b]) sram[o_mem_addr[11:2]][b*8 +: 8] <= o_mem_wr_data[b*8 +: 8];
        if (o_mem_read)
            sram_q <= sram[o_mem_addr[11:2]];
    end
    assign i_mem_rd_data = sram_q;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic creq, input logic cwe, input logic [31:0] caddr,
                         input logic [31:0] cwd, input logic [3:0] csz,
                         input logic dreq, input logic dwe, input logic [31:0] daddr,
                         input logic [31:0] dwd, input logic [3:0] dsz);
        i_core_req = creq; i_core_we = cwe; i_core_addr = caddr;
        i_core_wdata = cwd; i_core_size = csz;
        i_dma_req = dreq; i_dma_we = dwe; i_dma_addr = daddr;
        i_dma_wdata = dwd; i_dma_size = dsz;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        drive(1, 0, 32'h10, 0, 4'hF, 1, 1, 32'h8, 32'h55, 4'hF);
        @(negedge i_clk);
        checks++;
        if ({o_core_gnt, o_dma_gnt, o_mem_read, o_mem_write} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_gnt got=%b exp=0000", {o_core_gnt, o_dma_gnt, o_mem_read, o_mem_write});
        end
        checks++;
        if ({o_core_rvalid, o_dma_rvalid} !== 2'b00 || o_core_rdata !== 32'h0 || o_dma_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rd got rv=%b crd=%h drd=%h exp rv=00 rd=0",
                     {o_core_rvalid, o_dma_rvalid}, o_core_rdata, o_dma_rdata);
        end
        next_cycle();
        i_rst = 1'b0;
        idle();
    endtask

    task automatic test_core_read();
        drive(1, 1, 32'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0);
        next_cycle();
        drive(1, 0, 32'h010, 0, 4'hF, 0, 0, 0, 0, 0);
        @(negedge i_clk);
        checks++;
        if (o_core_gnt !== 1'b1 || o_dma_gnt !== 1'b0) begin
            failures++;
            $display("FAIL core_rd_gnt got c=%b d=%b exp c=1 d=0", o_core_gnt, o_dma_gnt);
        end
        checks++;
        if (o_mem_read !== 1'b1 || o_mem_write !== 1'b0 || o_mem_addr !== 32'h010) begin
            failures++;
            $display("FAIL core_rd_mem got rd=%b wr=%b a=%h exp rd=1 wr=0 a=010", o_mem_read, o_mem_write, o_mem_addr);
        end
        next_cycle();
        idle();
        @(negedge i_clk);
        checks++;
        if (o_core_rvalid !== 1'b1 || o_core_rdata !== 32'hDEADBEEF || o_dma_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL core_rd_ret got rv=%b d=%h drv=%b exp rv=1 d=deadbeef drv=0",
                     o_core_rvalid, o_core_rdata, o_dma_rvalid);
        end
        next_cycle();
    endtask

    task automatic test_alternating();
        drive(1, 1, 32'h004, 32'hA0A00004, 4'hF, 0, 0, 0, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 1, 1, 32'h008, 32'hB0B00008, 4'hF);
        next_cycle();
        drive(1, 0, 32'h004, 0, 4'hF, 0, 0, 0, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 1, 0, 32'h008, 0, 4'hF);
        @(negedge i_clk);
        checks++;
        if (o_dma_gnt !== 1'b1 || o_core_rvalid !== 1'b1 || o_core_rdata !== 32'hA0A00004 || o_dma_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL alt_core_ret got dg=%b crv=%b cd=%h drv=%b exp 1 1 a0a00004 0",
                     o_dma_gnt, o_core_rvalid, o_core_rdata, o_dma_rvalid);
        end
        next_cycle();
        idle();
        @(negedge i_clk);
        checks++;
        if (o_dma_rvalid !== 1'b1 || o_dma_rdata !== 32'hB0B00008 || o_core_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL alt_dma_ret got drv=%b dd=%h crv=%b exp 1 b0b00008 0",
                     o_dma_rvalid, o_dma_rdata, o_core_rvalid);
        end
        checks++;
        if (o_core_rdata !== 32'hA0A00004) begin
            failures++;
            $display("FAIL alt_core_hold got=%h exp=a0a00004", o_core_rdata);
        end
        next_cycle();
    endtask

    task automatic test_starvation();
        drive(1, 0, 32'h004, 0, 4'hF, 1, 0, 32'h008, 0, 4'hF);
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            checks++;
            if (o_dma_gnt !== (i == 4) || o_core_gnt !== (i != 4)) begin
                failures++;
                $display("FAIL starve_gnt cyc=%0d got c=%b d=%b exp c=%b d=%b",
                         i, o_core_gnt, o_dma_gnt, i != 4, i == 4);
            end
            if (i >= 1) begin
                checks++;
                if (o_core_rvalid !== (i != 5) || o_dma_rvalid !== (i == 5)) begin
                    failures++;
                    $display("FAIL starve_rv cyc=%0d got c=%b d=%b exp c=%b d=%b",
                             i, o_core_rvalid, o_dma_rvalid, i != 5, i == 5);
                end
            end
            next_cycle();
        end
        idle();
        next_cycle();
    endtask

    task automatic test_byte_write();
        drive(1, 1, 32'h020, 32'h11223344, 4'hF, 0, 0, 0, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 1, 1, 32'h020, 32'h0000AB00, 4'b0010);
        @(negedge i_clk);
        checks++;
        if (o_dma_gnt !== 1'b1 || o_mem_write !== 1'b1 || o_mem_size !== 4'b0010 || o_mem_wr_data !== 32'h0000AB00) begin
            failures++;
            $display("FAIL bytewr_mem got g=%b w=%b sz=%b d=%h exp 1 1 0010 0000ab00",
                     o_dma_gnt, o_mem_write, o_mem_size, o_mem_wr_data);
        end
        next_cycle();
        drive(0, 0, 0, 0, 0, 1, 0, 32'h020, 0, 4'hF);
        next_cycle();
        idle();
        @(negedge i_clk);
        checks++;
        if (o_dma_rvalid !== 1'b1 || o_dma_rdata !== 32'h1122AB44) begin
            failures++;
            $display("FAIL bytewr_rd got rv=%b d=%h exp rv=1 d=1122ab44", o_dma_rvalid, o_dma_rdata);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        // Three refusals leave the starvation counter one short of forcing.
        drive(1, 0, 32'h010, 0, 4'hF, 1, 0, 32'h008, 0, 4'hF);
        next_cycle();
        next_cycle();
        next_cycle();
        i_rst = 1'b1;
        @(negedge i_clk);
        checks++;
        if ({o_core_rvalid, o_dma_rvalid, o_core_gnt, o_dma_gnt, o_mem_read, o_mem_write} !== 6'b0) begin
            failures++;
            $display("FAIL rstmid_out got rv=%b%b g=%b%b rd=%b wr=%b exp all 0",
                     o_core_rvalid, o_dma_rvalid, o_core_gnt, o_dma_gnt, o_mem_read, o_mem_write);
        end
        next_cycle();
        i_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            if (i == 0) begin
                checks++;
                if (o_core_rvalid !== 1'b0 || o_core_rdata !== 32'h0) begin
                    failures++;
                    $display("FAIL rstmid_rv got rv=%b d=%h exp rv=0 d=0", o_core_rvalid, o_core_rdata);
                end
            end
            checks++;
            if (o_dma_gnt !== (i == 4) || o_core_gnt !== (i != 4)) begin
                failures++;
                $display("FAIL rstmid_arb cyc=%0d got c=%b d=%b exp c=%b d=%b",
                         i, o_core_gnt, o_dma_gnt, i != 4, i == 4);
            end
            next_cycle();
        end
        idle();
        next_cycle();
    endtask

    task automatic test_force_drop();
        drive(1, 0, 32'h004, 0, 4'hF, 1, 0, 32'h008, 0, 4'hF);
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            checks++;
            if (o_core_gnt !== 1'b1 || o_dma_gnt !== 1'b0) begin
                failures++;
                $display("FAIL drop_pre cyc=%0d got c=%b d=%b exp c=1 d=0", i, o_core_gnt, o_dma_gnt);
            end
            next_cycle();
        end
        drive(1, 0, 32'h004, 0, 4'hF, 0, 0, 0, 0, 0);
        @(negedge i_clk);
        checks++;
        if ({o_core_gnt, o_dma_gnt, o_mem_read, o_mem_write} !== 4'b0000) begin
            failures++;
            $display("FAIL drop_slot got g=%b%b rd=%b wr=%b exp 0000", o_core_gnt, o_dma_gnt, o_mem_read, o_mem_write);
        end
        next_cycle();
        @(negedge i_clk);
        checks++;
        if (o_core_gnt !== 1'b1) begin
            failures++;
            $display("FAIL drop_after got c=%b exp c=1", o_core_gnt);
        end
        next_cycle();
        idle();
        next_cycle();
    endtask

    task automatic test_random();
        int          refusals = 0;
        bit          force_pend = 0;
        logic [31:0] ref_mem [16];
        bit          pend_c = 0, pend_d = 0;
        logic [31:0] pend_data = 0, last_c = 0, last_d = 0;
        logic        creq, cwe, dreq, dwe, exp_c, exp_d;
        logic [31:0] caddr, cwd, daddr, dwd, t, gaddr, gwd;
        logic [3:0]  csz, dsz, gsz, w;
        logic        gwe;

        i_rst = 1'b1;
        idle();
        next_cycle();
        i_rst = 1'b0;
        for (int n = 0; n < 16 + 400; n++) begin
            if (n < 16) begin
                creq = 1; cwe = 1; caddr = 32'(n) << 2; cwd = $urandom(); csz = 4'hF;
                dreq = 0; dwe = 0; daddr = 0; dwd = 0; dsz = 0;
            end else begin
                creq = ($urandom_range(0, 3) != 0); cwe = $urandom_range(0, 1) == 1;
                t = $urandom(); caddr = {t[31:12], 6'b0, 4'($urandom_range(0, 15)), 2'b00};
                cwd = $urandom(); csz = 4'($urandom_range(0, 15));
                dreq = ($urandom_range(0, 4) > 1); dwe = $urandom_range(0, 1) == 1;
                t = $urandom(); daddr = {t[31:12], 6'b0, 4'($urandom_range(0, 15)), 2'b00};
                dwd = $urandom(); dsz = 4'($urandom_range(0, 15));
            end
            drive(creq, cwe, caddr, cwd, csz, dreq, dwe, daddr, dwd, dsz);

            // Priority rule: CORE first, but the MAX_WAIT-th straight refusal of a
            // waiting DMA earns it the following cycle outright.
            if (force_pend) begin
                exp_c = 0; exp_d = dreq; force_pend = 0; refusals = 0;
            end else begin
                exp_c = creq; exp_d = !creq && dreq;
                if (creq && dreq) begin
                    refusals++;
                    if (refusals == MAX_WAIT) force_pend = 1;
                end else
                    refusals = 0;
            end
            gaddr = exp_c ? caddr : (exp_d ? daddr : 32'h0);
            gwd   = exp_c ? cwd   : (exp_d ? dwd   : 32'h0);
            gsz   = exp_c ? csz   : (exp_d ? dsz   : 4'h0);
            gwe   = exp_c ? cwe   : (exp_d ? dwe   : 1'b0);

            @(negedge i_clk);
            checks++;
            if (o_core_gnt !== exp_c || o_dma_gnt !== exp_d) begin
                failures++;
                $display("FAIL rnd_gnt n=%0d got c=%b d=%b exp c=%b d=%b", n, o_core_gnt, o_dma_gnt, exp_c, exp_d);
            end
            checks++;
            if (o_mem_addr !== gaddr || o_mem_write !== ((exp_c || exp_d) && gwe) ||
                o_mem_read !== ((exp_c || exp_d) && !gwe) ||
                (o_mem_write && (o_mem_wr_data !== gwd || o_mem_size !== gsz))) begin
                failures++;
                $display("FAIL rnd_mem n=%0d got a=%h w=%b r=%b d=%h s=%h exp a=%h we=%b d=%h s=%h",
                         n, o_mem_addr, o_mem_write, o_mem_read, o_mem_wr_data, o_mem_size, gaddr, gwe, gwd, gsz);
            end
            if (pend_c) last_c = pend_data;
            if (pend_d) last_d = pend_data;
            checks++;
            if (o_core_rvalid !== pend_c || o_dma_rvalid !== pend_d ||
                o_core_rdata !== last_c || o_dma_rdata !== last_d) begin
                failures++;
                $display("FAIL rnd_ret n=%0d got rv=%b%b cd=%h dd=%h exp rv=%b%b cd=%h dd=%h",
                         n, o_core_rvalid, o_dma_rvalid, o_core_rdata, o_dma_rdata, pend_c, pend_d, last_c, last_d);
            end

            w = gaddr[5:2];
            pend_c = exp_c && !gwe;
            pend_d = exp_d && !gwe;
            if (pend_c || pend_d) pend_data = ref_mem[w];
            if ((exp_c || exp_d) && gwe)
                for (int b = 0; b < 4; b++)
                    if (gsz[b]) ref_mem[w][b*8 +: 8] = gwd[b*8 +: 8];
            next_cycle();
        end
        idle();
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_core_read();
        test_alternating();
        test_starvation();
        test_byte_write();
        test_reset_mid_read();
        test_force_drop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
